// File: rtl/spi_master_pkg.sv
// spi_master_pkg: FSM state encoding and default frame timing constants
// shared by the SPI frame master, its phase timer and its interface users.
package spi_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_HIGH,
    S_LOW,
    S_LAG,
    S_GAP
  } state_e;

  localparam int NB_DEF   = 20;
  localparam int DIV_DEF  = 4;
  localparam int LEAD_DEF = 4;
  localparam int LAG_DEF  = 4;
  localparam int GAP_DEF  = 8;

  // phase timer width, wide enough for DIV + LAG and GAP
  localparam int TW = 16;

endpackage

// File: rtl/spi_frame_master_if.sv
// spi_frame_master_if: frame control, TX write, RX read and SPI pins.
// master = the frame master itself; slave = host/pin side driving it.
interface spi_frame_master_if;

  logic       start;
  logic       busy;
  logic       done;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_err;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       SCK;
  logic       SSEL;
  logic       MOSI;
  logic       MISO;

  modport master (
    input  start, wr_en, wr_addr, wr_data,
    input  rd_addr, MISO,
    output busy, done, wr_err, rd_data,
    output SCK, SSEL, MOSI
  );

  modport slave (
    output start, wr_en, wr_addr, wr_data,
    output rd_addr, MISO,
    input  busy, done, wr_err, rd_data,
    input  SCK, SSEL, MOSI
  );

endinterface

// File: rtl/spi_phase_timer.sv
// spi_phase_timer: loadable down-counter timing each FSM phase.
// Ports: clk, rst, load, load_val (phase length in cycles), tick (last cycle).
module spi_phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  logic [W-1:0] cnt_q, cnt_d;

  // a phase of N cycles holds N-1 .. 0, tick marks the final cycle
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val - W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/spi_frame_master.sv
// spi_frame_master: SPI mode-0 master shifting NB bytes per frame.
// Ports: clk, rst (sync, active high), bus (spi_frame_master_if.master).
module spi_frame_master
  import spi_master_pkg::*;
#(
  parameter int NB   = NB_DEF,
  parameter int DIV  = DIV_DEF,
  parameter int LEAD = LEAD_DEF,
  parameter int LAG  = LAG_DEF,
  parameter int GAP  = GAP_DEF
) (
  input logic clk,
  input logic rst,
  spi_frame_master_if.master bus
);

  state_e     state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [4:0] byte_q, byte_d;
  logic [6:0] sh_q, sh_d;
  logic       wr_err_q, wr_err_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic [7:0] tx_q [NB];
  logic [7:0] rx_q [NB];

  logic          tick;
  logic          load;
  logic [TW-1:0] load_val;
  logic          sample;
  logic          last_bit;
  logic          wr_ok;
  logic          rd_ok;
  logic          rx_we;
  logic [7:0]    rx_byte;

  assign last_bit = (bit_q == 3'd7)
                 && (byte_q == 5'(NB - 1));
  assign sample   = (state_q == S_HIGH) && tick;
  assign rx_byte  = {sh_q, bus.MISO};
  assign rx_we    = sample && (bit_q == 3'd7);
  assign wr_ok    = bus.wr_en
                 && (state_q == S_IDLE)
                 && (32'(bus.wr_addr) < NB);
  assign rd_ok    = (32'(bus.rd_addr) < NB);

  spi_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .tick     (tick)
  );

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start) state_d = S_LEAD;
      S_LEAD: if (tick) state_d = S_HIGH;
      S_HIGH: if (tick) state_d = last_bit ? S_LAG : S_LOW;
      S_LOW:  if (tick) state_d = S_HIGH;
      S_LAG:  if (tick) state_d = S_GAP;
      // the last GAP cycle already meets the minimum gap, so a
      // pending start chains the next frame with no idle cycle
      S_GAP:  if (tick) state_d = bus.start ? S_LEAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // phase length of the state being entered; LAG also absorbs the
  // trailing low half of the final SCK period so the frame keeps
  // NB*8 whole SCK periods
  always_comb begin
    load = (state_d != state_q) && (state_d != S_IDLE);
    unique case (state_d)
      S_LEAD:        load_val = TW'(LEAD);
      S_HIGH, S_LOW: load_val = TW'(DIV);
      S_LAG:         load_val = TW'(DIV + LAG);
      S_GAP:         load_val = TW'(GAP);
      default:       load_val = '0;
    endcase
  end

  // counters advance on the sample so LOW already shows the next bit;
  // on the final bit they hold, keeping MOSI steady through LAG
  always_comb begin
    bit_d    = bit_q;
    byte_d   = byte_q;
    sh_d     = sh_q;
    wr_err_d = bus.wr_en && !wr_ok;
    if (sample) begin
      sh_d = {sh_q[5:0], bus.MISO};
      if (!last_bit) begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) byte_d = byte_q + 5'd1;
      end
    end
    if (state_q == S_IDLE || state_q == S_GAP) begin
      bit_d  = '0;
      byte_d = '0;
      sh_d   = '0;
    end
    rd_data_d = rd_ok ? rx_q[bus.rd_addr] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bit_q    <= '0;
      byte_q   <= '0;
      sh_q     <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      sh_q     <= sh_d;
      wr_err_q <= wr_err_d;
    end
  end

  // buffers survive reset
  always_ff @(posedge clk) begin
    if (wr_ok) tx_q[bus.wr_addr] <= bus.wr_data;
    if (rx_we) rx_q[byte_q] <= rx_byte;
    rd_data_q <= rd_data_d;
  end

  // outputs
  always_comb begin
    bus.SSEL = 1'b1;
    bus.SCK  = 1'b0;
    bus.MOSI = 1'b0;
    bus.done = 1'b0;
    bus.busy = (state_q != S_IDLE);
    unique case (state_q)
      S_LEAD, S_LOW, S_LAG: begin
        bus.SSEL = 1'b0;
        bus.MOSI = tx_q[byte_q][~bit_q];
      end
      S_HIGH: begin
        bus.SSEL = 1'b0;
        bus.SCK  = 1'b1;
        bus.MOSI = tx_q[byte_q][~bit_q];
      end
      S_GAP:   bus.done = tick;
      default: ;
    endcase
  end

  assign bus.wr_err  = wr_err_q;
  assign bus.rd_data = rd_data_q;

endmodule

// File: doc/spi_frame_master.md
SPI_FRAME_MASTER -- requirements
Module: spi_frame_master

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (all state on posedge clk) and rst.
REQ-002 Parameter NB, default 20: bytes per frame, range 1..32.
REQ-003 Parameter DIV, default 4: SCK half-period in clk cycles, legal range 4..255.
REQ-004 Parameter LEAD, default 4: clk cycles from SSEL low to the first SCK rise.
REQ-005 Parameter LAG, default 4: clk cycles from the last SCK fall to SSEL high.
REQ-006 Parameter GAP, default 8: minimum clk cycles SSEL stays high between frames.
REQ-007 Port clk, input, 1 bit: system clock.
REQ-008 Port rst, input, 1 bit: synchronous active-high reset.
REQ-009 Port start, input, 1 bit: one-cycle frame request.
REQ-010 Port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-011 Port done, output, 1 bit: one-cycle pulse at frame end.
REQ-012 Port wr_en / wr_addr / wr_data, input, 1 / 5 / 8 bits: TX buffer write port.
REQ-013 Port wr_err, output, 1 bit: one-cycle pulse when a write is rejected.
REQ-014 Port rd_addr / rd_data, input 5 / output 8 bits: RX buffer read port.
REQ-015 Port SCK, SSEL, MOSI, output, 1 bit each: SPI mode 0; SSEL is active low.
REQ-016 Port MISO, input, 1 bit: serial data from the slave.

Function
REQ-017 FSM states SHALL be IDLE, LEAD, HIGH, LOW, LAG, GAP.
REQ-018 In IDLE: SSEL=1, SCK=0, MOSI=0; start moves the FSM to LEAD on the next edge; start in any other state is ignored.
REQ-019 LEAD: SSEL=0, SCK=0, MOSI=tx[0][7], held LEAD cycles, then HIGH.
REQ-020 HIGH: SCK=1 for DIV cycles.
REQ-021 MISO SHALL be sampled in the last cycle of HIGH and shifted into the RX shift register, MSB first.
REQ-022 LOW: SCK=0 for DIV cycles; MOSI SHALL update to the next bit on entry to LOW (the SCK falling transition).
REQ-023 After bit 0 of byte NB-1, the FSM SHALL go to LAG instead of LOW; SCK=0, SSEL=0 for LAG cycles.
REQ-024 GAP: SSEL=1 for GAP cycles; done SHALL pulse in the last GAP cycle, and the FSM then returns to IDLE.
REQ-025 Frame length SHALL be LEAD + NB*16*DIV + LAG + GAP cycles (1296 at defaults), with exactly NB*8 SCK rising edges.
REQ-026 After each 8th sample, the completed byte SHALL be written to rx[byte index].
REQ-027 Bytes SHALL be sent in index order, MSB first.
REQ-028 TX writes SHALL be accepted only in IDLE.
REQ-029 A write while busy, or with wr_addr >= NB, SHALL be dropped and SHALL pulse wr_err the next cycle.
REQ-030 rd_data SHALL be registered, with one-cycle latency.
REQ-031 A read with rd_addr >= NB SHALL return 8'h00.
REQ-032 Reads during a frame SHALL return the current buffer contents, which may be partially updated.
REQ-033 start and wr_en asserted in the same IDLE cycle: the write SHALL commit first and the frame SHALL use the new byte.
REQ-034 The bit counter SHALL be 3 bits and wrap at 8; the byte counter SHALL be 5 bits and SHALL never exceed NB-1.

Reset
REQ-035 rst SHALL force IDLE, SSEL=1, SCK=0, MOSI=0, busy=0, done=0, wr_err=0, and clear all counters, from any state including mid-byte.
REQ-036 After a mid-frame reset, the partial RX byte SHALL be discarded and no done pulse SHALL occur.
REQ-037 Buffer contents SHALL NOT be cleared by rst.

Structure
REQ-038 Package spi_master_pkg SHALL hold the FSM state enum and the default NB/DIV/LEAD/LAG/GAP constants.
REQ-039 The half-period/LEAD/LAG/GAP down-counter SHALL be one sub-module, spi_phase_timer (load value, tick at zero).
REQ-040 Buffers SHALL be flop arrays, NB x 8 for each of TX and RX.

Verification
REQ-041 Reset then idle 100 cycles -> SSEL=1, SCK=0, busy=0, no done.
REQ-042 MOSI looped to MISO, tx[k]=k*8'h0D (mod 256), start -> rx[k]==tx[k] for k=0..19; done exactly 1296 cycles after start; 160 SCK rises counted.
REQ-043 SPI-slave model driving bytes 8'hA5, 8'h3C, ... -> rx matches; each MOSI edge lies within LOW, never within HIGH.
REQ-044 Write at cycle 50 of a frame -> wr_err pulse, tx unchanged; write with wr_addr=25 -> wr_err pulse.
REQ-045 rst asserted in byte 7 -> next cycle SSEL=1, SCK=0, busy=0, no done; a following frame completes normally.
REQ-046 start held high for 3000 cycles -> back-to-back frames, SSEL high exactly GAP cycles between them, done once per frame.
